// File: rtl/alu_mode_controller_pkg.sv
// Shared mode encoding and default timing for the switch/key operation datapath controller.
package alu_mode_controller_pkg;

    typedef enum logic [1:0] {
        MODE_CMP = 2'd0,
        MODE_LOG = 2'd1,
        MODE_ARI = 2'd2,
        MODE_LED = 2'd3
    } mode_e;

    localparam int DEF_DEBOUNCE_CYCLES = 100000;
    localparam int DEF_LONG_CYCLES     = 10000000;
    localparam int DEF_AUTO_PERIOD     = 10000000;

    function automatic logic [1:0] next_mode(input logic [1:0] cur);
        logic [1:0] nxt;
        case (cur)
            MODE_CMP: nxt = MODE_LOG;
            MODE_LOG: nxt = MODE_ARI;
            MODE_ARI: nxt = MODE_LED;
            MODE_LED: nxt = MODE_CMP;
            default:  nxt = MODE_CMP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/alu_mode_controller_key_debounce.sv
// Two-flop synchronizer plus stability counter for one active-low push-button.
// level is 1 while the debounced key is pressed; press/release pulse for one cycle on acceptance.
module key_debounce
    import alu_mode_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_r;
    logic          key_pressed_s;
    logic          level_r;
    logic          press_r;
    logic          release_r;
    logic [CW-1:0] cnt_r;

    // Synchronizer: resets to released so a held key is seen as a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], key_raw};
        end
    end

    assign key_pressed_s = ~sync_r[1];

    // Debounce counter restarts on any agreement; level flips only after a full stable window.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
            if (key_pressed_s == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                level_r   <= key_pressed_s;
                press_r   <= key_pressed_s;
                release_r <= ~key_pressed_s;
                cnt_r     <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign level         = level_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;

endmodule

// File: rtl/alu_mode_controller.sv
// Mode sequencing controller: debounced keys step the unit select, KEY[1] short/long press
// toggles operand hold / auto-cycling, and switches are synchronized into operand registers.
module alu_mode_controller
    import alu_mode_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int AUTO_PERIOD     = DEF_AUTO_PERIOD
) (
    input  logic       ADC_CLK_10,
    input  logic       RST,
    input  logic [1:0] KEY,
    input  logic [9:0] SW,
    output logic [1:0] mode,
    output logic [1:0] sub_sel,
    output logic [3:0] x_op,
    output logic [3:0] y_op,
    output logic       hold,
    output logic       auto_en,
    output logic       mode_stb
);

    localparam int LW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam int PW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(AUTO_PERIOD - 1);

    logic          key0_level_unused_s;
    logic          key0_press_s;
    logic          key0_release_unused_s;
    logic          key1_level_s;
    logic          key1_press_s;
    logic          key1_release_s;

    logic [9:0]    sw_meta_r;
    logic [9:0]    sw_sync_r;
    logic [3:0]    x_op_r;
    logic [3:0]    y_op_r;
    logic [1:0]    sub_sel_r;
    logic          hold_r;
    logic          auto_en_r;
    logic [1:0]    mode_r;
    logic          mode_stb_r;
    logic          long_busy_r;
    logic [LW-1:0] long_cnt_r;
    logic [PW-1:0] per_cnt_r;

    logic          hold_tgl_s;
    logic          auto_tgl_s;
    logic          auto_step_s;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
        .clk           (ADC_CLK_10),
        .rst           (RST),
        .key_raw       (KEY[0]),
        .level         (key0_level_unused_s),
        .press_pulse   (key0_press_s),
        .release_pulse (key0_release_unused_s)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
        .clk           (ADC_CLK_10),
        .rst           (RST),
        .key_raw       (KEY[1]),
        .level         (key1_level_s),
        .press_pulse   (key1_press_s),
        .release_pulse (key1_release_s)
    );

    // Switch synchronizer.
    always_ff @(posedge ADC_CLK_10) begin
        if (RST) begin
            sw_meta_r <= 10'd0;
            sw_sync_r <= 10'd0;
        end else begin
            sw_meta_r <= SW;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Operand and sub-op registers follow the switches unless frozen.
    always_ff @(posedge ADC_CLK_10) begin
        if (RST) begin
            x_op_r    <= 4'd0;
            y_op_r    <= 4'd0;
            sub_sel_r <= 2'd0;
        end else if (!hold_r) begin
            x_op_r    <= sw_sync_r[3:0];
            y_op_r    <= sw_sync_r[7:4];
            sub_sel_r <= sw_sync_r[9:8];
        end else begin
            x_op_r    <= x_op_r;
            y_op_r    <= y_op_r;
            sub_sel_r <= sub_sel_r;
        end
    end

    // Short release toggles hold; reaching the long threshold toggles auto and disarms the release.
    always_comb begin
        hold_tgl_s = 1'b0;
        auto_tgl_s = 1'b0;
        if (long_busy_r && key1_release_s) begin
            hold_tgl_s = 1'b1;
        end else if (long_busy_r && key1_level_s && (long_cnt_r == LONG_LAST)) begin
            auto_tgl_s = 1'b1;
        end else begin
            hold_tgl_s = 1'b0;
            auto_tgl_s = 1'b0;
        end
    end

    // KEY[1] press timer; the press-pulse cycle counts as timer value 0.
    always_ff @(posedge ADC_CLK_10) begin
        if (RST) begin
            long_busy_r <= 1'b0;
            long_cnt_r  <= '0;
        end else if (key1_press_s) begin
            long_busy_r <= 1'b1;
            long_cnt_r  <= LW'(1);
        end else if (hold_tgl_s || auto_tgl_s) begin
            long_busy_r <= 1'b0;
            long_cnt_r  <= '0;
        end else if (long_busy_r) begin
            long_cnt_r  <= long_cnt_r + LW'(1);
        end else begin
            long_cnt_r  <= '0;
        end
    end

    // Hold and auto-cycle flags.
    always_ff @(posedge ADC_CLK_10) begin
        if (RST) begin
            hold_r    <= 1'b0;
            auto_en_r <= 1'b0;
        end else begin
            hold_r    <= hold_r ^ hold_tgl_s;
            auto_en_r <= auto_en_r ^ auto_tgl_s;
        end
    end

    assign auto_step_s = auto_en_r && (per_cnt_r == PER_LAST);

    // Auto period counter; a manual step or an auto_en change restarts the interval.
    always_ff @(posedge ADC_CLK_10) begin
        if (RST) begin
            per_cnt_r <= '0;
        end else if (auto_tgl_s || key0_press_s || auto_step_s || !auto_en_r) begin
            per_cnt_r <= '0;
        end else begin
            per_cnt_r <= per_cnt_r + PW'(1);
        end
    end

    // Mode register: a manual press and an auto step in the same cycle advance only once.
    always_ff @(posedge ADC_CLK_10) begin
        if (RST) begin
            mode_r     <= 2'd0;
            mode_stb_r <= 1'b0;
        end else if (key0_press_s || auto_step_s) begin
            mode_r     <= next_mode(mode_r);
            mode_stb_r <= 1'b1;
        end else begin
            mode_r     <= mode_r;
            mode_stb_r <= 1'b0;
        end
    end

    assign mode     = mode_r;
    assign sub_sel  = sub_sel_r;
    assign x_op     = x_op_r;
    assign y_op     = y_op_r;
    assign hold     = hold_r;
    assign auto_en  = auto_en_r;
    assign mode_stb = mode_stb_r;

endmodule

// File: tb/tb_alu_mode_controller.sv
// Directed bench for alu_mode_controller with short debounce/long/auto timing.
module tb_alu_mode_controller;

    logic       clk;
    logic       rst;
    logic [1:0] key;
    logic [9:0] sw;
    logic [1:0] mode;
    logic [1:0] sub_sel;
    logic [3:0] x_op;
    logic [3:0] y_op;
    logic       hold;
    logic       auto_en;
    logic       mode_stb;

    int total = 0;
    int bad   = 0;

    alu_mode_controller #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .AUTO_PERIOD     (8)
    ) dut (
        .ADC_CLK_10 (clk),
        .RST        (rst),
        .KEY        (key),
        .SW         (sw),
        .mode       (mode),
        .sub_sel    (sub_sel),
        .x_op       (x_op),
        .y_op       (y_op),
        .hold       (hold),
        .auto_en    (auto_en),
        .mode_stb   (mode_stb)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_m;
        int         n_stb;

        rst = 1'b1;
        key = 2'b11;
        sw  = 10'd0;
        ticks(3);
        chk("rst_mode",    32'(mode),     32'd0);
        chk("rst_stb",     32'(mode_stb), 32'd0);
        chk("rst_x",       32'(x_op),     32'd0);
        chk("rst_y",       32'(y_op),     32'd0);
        chk("rst_sub",     32'(sub_sel),  32'd0);
        chk("rst_hold",    32'(hold),     32'd0);
        chk("rst_auto",    32'(auto_en),  32'd0);
        rst = 1'b0;
        ticks(2);

        // Four clean KEY[0] presses: mode 1,2,3,0, each landing 7 cycles after the edge.
        exp_m = 2'd0;
        for (int k = 0; k < 4; k++) begin
            key[0] = 1'b0;
            ticks(6);
            chk("press_mode_before", 32'(mode), 32'(exp_m));
            chk("press_stb_before",  32'(mode_stb), 32'd0);
            ticks(1);
            exp_m = exp_m + 2'd1;
            chk("press_mode_after",  32'(mode), 32'(exp_m));
            chk("press_stb_pulse",   32'(mode_stb), 32'd1);
            ticks(1);
            chk("press_stb_single",  32'(mode_stb), 32'd0);
            ticks(2);
            key[0] = 1'b1;
            ticks(10);
        end
        chk("press_wrap", 32'(mode), 32'd0);

        // Three-cycle glitch must be rejected.
        key[0] = 1'b0;
        ticks(3);
        key[0] = 1'b1;
        n_stb = 0;
        for (int i = 0; i < 12; i++) begin
            ticks(1);
            if (mode_stb) n_stb++;
        end
        chk("glitch_stb",  32'(n_stb), 32'd0);
        chk("glitch_mode", 32'(mode),  32'd0);

        // Switch capture and hold toggling.
        sw = 10'b10_0110_1001;
        ticks(2);
        chk("sw_lat_early", 32'(x_op), 32'd0);
        ticks(1);
        chk("sw_x",   32'(x_op),    32'd9);
        chk("sw_y",   32'(y_op),    32'd6);
        chk("sw_sub", 32'(sub_sel), 32'd2);
        key[1] = 1'b0;
        ticks(8);
        key[1] = 1'b1;
        ticks(6);
        chk("hold_before", 32'(hold), 32'd0);
        ticks(1);
        chk("hold_set",    32'(hold),    32'd1);
        chk("hold_noauto", 32'(auto_en), 32'd0);
        sw = 10'd0;
        ticks(5);
        chk("held_x",   32'(x_op),    32'd9);
        chk("held_y",   32'(y_op),    32'd6);
        chk("held_sub", 32'(sub_sel), 32'd2);
        key[1] = 1'b0;
        ticks(8);
        key[1] = 1'b1;
        ticks(7);
        chk("hold_clear", 32'(hold), 32'd0);
        ticks(3);
        chk("unheld_x",   32'(x_op),    32'd0);
        chk("unheld_y",   32'(y_op),    32'd0);
        chk("unheld_sub", 32'(sub_sel), 32'd0);

        // Long KEY[1] press enables auto-cycling (t=0 at the press edge).
        key[1] = 1'b0;
        ticks(25);
        chk("long_auto_before", 32'(auto_en), 32'd0);
        ticks(1);                                   // t=26
        chk("long_auto_set",  32'(auto_en), 32'd1);
        chk("long_hold_same", 32'(hold),    32'd0);
        ticks(7);                                   // t=33
        chk("auto_step1_before", 32'(mode), 32'd0);
        ticks(1);                                   // t=34
        chk("auto_step1",     32'(mode),     32'd1);
        chk("auto_step1_stb", 32'(mode_stb), 32'd1);
        ticks(1);                                   // t=35
        chk("auto_step1_stb_end", 32'(mode_stb), 32'd0);
        ticks(5);                                   // t=40
        key[1] = 1'b1;
        ticks(2);                                   // t=42
        chk("auto_step2", 32'(mode), 32'd2);
        ticks(8);                                   // t=50
        chk("auto_step3",     32'(mode),     32'd3);
        chk("long_release_hold", 32'(hold),  32'd0);
        ticks(3);                                   // t=53
        key[0] = 1'b0;
        ticks(5);                                   // t=58
        chk("auto_step4", 32'(mode), 32'd0);
        ticks(2);                                   // t=60
        chk("auto_manual",     32'(mode),     32'd1);
        chk("auto_manual_stb", 32'(mode_stb), 32'd1);
        ticks(3);                                   // t=63
        key[0] = 1'b1;
        ticks(4);                                   // t=67
        chk("auto_restart_wait", 32'(mode), 32'd1);
        ticks(1);                                   // t=68
        chk("auto_restart_step", 32'(mode), 32'd2);
        ticks(1);                                   // t=69
        key[0] = 1'b0;
        ticks(6);                                   // t=75
        chk("coinc_before", 32'(mode), 32'd2);
        ticks(1);                                   // t=76
        chk("coinc_mode", 32'(mode),     32'd3);
        chk("coinc_stb",  32'(mode_stb), 32'd1);
        ticks(1);                                   // t=77
        chk("coinc_mode_hold", 32'(mode),     32'd3);
        chk("coinc_stb_end",   32'(mode_stb), 32'd0);
        ticks(2);                                   // t=79
        key[0] = 1'b1;
        ticks(7);                                   // t=86
        chk("auto_step_after_coinc", 32'(mode), 32'd0);

        // Second long press disables auto-cycling; steps at t'=6,14,22 reach mode 3.
        key[1] = 1'b0;
        ticks(25);
        chk("long2_auto_before", 32'(auto_en), 32'd1);
        ticks(1);
        chk("long2_auto_clear", 32'(auto_en), 32'd0);
        ticks(14);
        key[1] = 1'b1;
        ticks(15);
        chk("long2_mode", 32'(mode), 32'd3);
        chk("long2_hold", 32'(hold), 32'd0);
        n_stb = 0;
        for (int i = 0; i < 20; i++) begin
            ticks(1);
            if (mode_stb) n_stb++;
        end
        chk("stopped_stb",  32'(n_stb), 32'd0);
        chk("stopped_mode", 32'(mode),  32'd3);

        // Reset in the middle of a KEY[0] debounce with the key still held.
        sw = 10'h3FF;
        ticks(4);
        chk("pre_rst_x", 32'(x_op), 32'hF);
        key[0] = 1'b0;
        ticks(2);
        rst = 1'b1;
        ticks(5);
        chk("mid_rst_mode", 32'(mode),     32'd0);
        chk("mid_rst_x",    32'(x_op),     32'd0);
        chk("mid_rst_y",    32'(y_op),     32'd0);
        chk("mid_rst_sub",  32'(sub_sel),  32'd0);
        chk("mid_rst_hold", 32'(hold),     32'd0);
        chk("mid_rst_auto", 32'(auto_en),  32'd0);
        chk("mid_rst_stb",  32'(mode_stb), 32'd0);
        rst = 1'b0;
        ticks(6);
        chk("post_rst_before", 32'(mode), 32'd0);
        ticks(1);
        chk("post_rst_press", 32'(mode),     32'd1);
        chk("post_rst_stb",   32'(mode_stb), 32'd1);
        key[0] = 1'b1;
        ticks(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
